// File: rtl/seg7_scan_if.sv
// Load handshake and scanned-display bus for the 4-digit seven-segment scan controller.
// master = requester/display side, slave = scan controller.
interface seg7_scan_if;
  logic       load_req;
  logic [7:0] num_l;
  logic [7:0] num_r;
  logic [3:0] dot_in;
  logic       blank_lz;
  logic       load_ack;
  logic [1:0] digit_sel;
  logic [3:0] nibble_out;
  logic       dot_out;
  logic [3:0] anode_out;

  modport master (
    output load_req, num_l, num_r, dot_in, blank_lz,
    input  load_ack, digit_sel, nibble_out, dot_out, anode_out
  );

  modport slave (
    input  load_req, num_l, num_r, dot_in, blank_lz,
    output load_ack, digit_sel, nibble_out, dot_out, anode_out
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 4-digit display scanner with frame-synchronous shadow loading,
// leading-zero blanking and registered one-cycle-latency outputs.
module seg7_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  seg7_scan_if.slave   bus
);

  localparam int unsigned  CW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);

  // Remaining cycles in the current digit slot; terminal count 0 is the tick.
  logic [CW-1:0] r_slot_rem;
  logic [1:0]    r_digit_idx;
  logic [15:0]   r_shadow;
  logic [3:0]    r_shadow_dot;
  logic          r_load_ack;
  logic [1:0]    r_digit_sel;
  logic [3:0]    r_nibble;
  logic          r_dot;
  logic [3:0]    r_anode;

  logic          w_tick;
  logic          w_frame;
  logic          w_capture;
  logic [3:0]    w_nib;
  logic          w_dot;
  logic [3:0]    w_lz;
  logic          w_blank;
  logic [3:0]    w_anode;

  assign w_tick    = (r_slot_rem == '0);
  assign w_frame   = w_tick && (r_digit_idx == 2'd3);
  assign w_capture = w_frame && bus.load_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot_rem   <= SLOT_LAST;
      r_digit_idx  <= 2'd0;
      r_shadow     <= 16'h0000;
      r_shadow_dot <= 4'h0;
      r_load_ack   <= 1'b0;
    end else begin
      r_slot_rem <= w_tick ? SLOT_LAST : r_slot_rem - 1'b1;
      if (w_tick) begin
        r_digit_idx <= r_digit_idx + 2'd1;
      end
      if (w_capture) begin
        r_shadow     <= {bus.num_l, bus.num_r};
        r_shadow_dot <= bus.dot_in;
      end
      r_load_ack <= w_capture;
    end
  end

  // A digit is a leading zero only if it and every digit to its left are zero with no dot.
  always_comb begin
    w_lz    = 4'b0000;
    w_lz[3] = (r_shadow[15:12] == 4'h0) && !r_shadow_dot[3];
    w_lz[2] = w_lz[3] && (r_shadow[11:8] == 4'h0) && !r_shadow_dot[2];
    w_lz[1] = w_lz[2] && (r_shadow[7:4] == 4'h0) && !r_shadow_dot[1];
  end

  always_comb begin
    w_nib = r_shadow[3:0];
    case (r_digit_idx)
      2'd0: w_nib = r_shadow[3:0];
      2'd1: w_nib = r_shadow[7:4];
      2'd2: w_nib = r_shadow[11:8];
      2'd3: w_nib = r_shadow[15:12];
      default: w_nib = r_shadow[3:0];
    endcase
    w_dot   = r_shadow_dot[r_digit_idx];
    w_blank = bus.blank_lz && w_lz[r_digit_idx];
    w_anode = w_blank ? 4'b1111 : ~(4'b0001 << r_digit_idx);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit_sel <= 2'd0;
      r_nibble    <= 4'h0;
      r_dot       <= 1'b0;
      r_anode     <= 4'b1111;
    end else begin
      r_digit_sel <= r_digit_idx;
      r_nibble    <= w_nib;
      r_dot       <= w_dot && !w_blank;
      r_anode     <= w_anode;
    end
  end

  assign bus.load_ack   = r_load_ack;
  assign bus.digit_sel  = r_digit_sel;
  assign bus.nibble_out = r_nibble;
  assign bus.dot_out    = r_dot;
  assign bus.anode_out  = r_anode;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with REFRESH_DIV=4: vector table for scan/load/blank,
// plus hand sequences for tear-free display, mid-frame reset and back-to-back loads.
module tb_seg7_scan_controller;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  seg7_scan_if bus();

  seg7_scan_controller #(.REFRESH_DIV(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         k;
    logic       req;
    logic [7:0] nl;
    logic [7:0] nr;
    logic [3:0] dots;
    logic       blz;
    logic [3:0] anode;
    logic [1:0] sel;
    logic [3:0] nib;
    logic       dot;
    logic       ack;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   ack_cnt = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge k after reset release is counted as cyc=k; outputs sampled 1 time unit later.
  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
    if (bus.load_ack === 1'b1) ack_cnt++;
  endtask

  task automatic step_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic drive(input logic req, input logic [7:0] nl, input logic [7:0] nr,
                       input logic [3:0] dots, input logic blz);
    bus.load_req = req;
    bus.num_l    = nl;
    bus.num_r    = nr;
    bus.dot_in   = dots;
    bus.blank_lz = blz;
  endtask

  task automatic release_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    cyc     = 0;
    ack_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " anode"}, {4'h0, bus.anode_out}, 8'h0F);
    chk({tag, " sel"},   {6'h0, bus.digit_sel}, 8'h00);
    chk({tag, " nib"},   {4'h0, bus.nibble_out}, 8'h00);
    chk({tag, " dot"},   {7'h0, bus.dot_out}, 8'h00);
    chk({tag, " ack"},   {7'h0, bus.load_ack}, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              k   req  nl     nr     dots     blz  anode    sel nib  dot ack
    vecs.push_back('{ 2, 1'b0, 8'h00, 8'h00, 4'h0,    1'b0, 4'b1110, 0, 4'h0, 0, 0});
    vecs.push_back('{ 5, 1'b0, 8'h00, 8'h00, 4'h0,    1'b0, 4'b1101, 1, 4'h0, 0, 0});
    vecs.push_back('{ 9, 1'b0, 8'h00, 8'h00, 4'h0,    1'b0, 4'b1011, 2, 4'h0, 0, 0});
    vecs.push_back('{13, 1'b1, 8'hA5, 8'h3C, 4'h0,    1'b0, 4'b0111, 3, 4'h0, 0, 0});
    vecs.push_back('{16, 1'b1, 8'hA5, 8'h3C, 4'h0,    1'b0, 4'b0111, 3, 4'h0, 0, 1});
    vecs.push_back('{17, 1'b0, 8'h12, 8'h34, 4'hF,    1'b0, 4'b1110, 0, 4'hC, 0, 0});
    vecs.push_back('{21, 1'b0, 8'hFF, 8'hFF, 4'hF,    1'b0, 4'b1101, 1, 4'h3, 0, 0});
    vecs.push_back('{25, 1'b0, 8'hFF, 8'hFF, 4'hF,    1'b0, 4'b1011, 2, 4'h5, 0, 0});
    vecs.push_back('{29, 1'b0, 8'h5A, 8'h5A, 4'h0,    1'b0, 4'b0111, 3, 4'hA, 0, 0});
    vecs.push_back('{32, 1'b0, 8'h5A, 8'h5A, 4'h0,    1'b0, 4'b0111, 3, 4'hA, 0, 0});
    vecs.push_back('{33, 1'b0, 8'h5A, 8'h5A, 4'h0,    1'b0, 4'b1110, 0, 4'hC, 0, 0});
    vecs.push_back('{37, 1'b1, 8'h00, 8'h07, 4'h0,    1'b1, 4'b1101, 1, 4'h3, 0, 0});
    vecs.push_back('{48, 1'b1, 8'h00, 8'h07, 4'h0,    1'b1, 4'b0111, 3, 4'hA, 0, 1});
    vecs.push_back('{49, 1'b0, 8'h00, 8'h07, 4'h0,    1'b1, 4'b1110, 0, 4'h7, 0, 0});
    vecs.push_back('{53, 1'b0, 8'h00, 8'h07, 4'h0,    1'b1, 4'b1111, 1, 4'h0, 0, 0});
    vecs.push_back('{57, 1'b0, 8'h00, 8'h07, 4'h0,    1'b1, 4'b1111, 2, 4'h0, 0, 0});
    vecs.push_back('{61, 1'b1, 8'h00, 8'h00, 4'h0,    1'b1, 4'b1111, 3, 4'h0, 0, 0});
    vecs.push_back('{64, 1'b1, 8'h00, 8'h00, 4'h0,    1'b1, 4'b1111, 3, 4'h0, 0, 1});
    vecs.push_back('{65, 1'b0, 8'h00, 8'h00, 4'h0,    1'b1, 4'b1110, 0, 4'h0, 0, 0});
    vecs.push_back('{69, 1'b1, 8'h00, 8'h00, 4'b0100, 1'b1, 4'b1111, 1, 4'h0, 0, 0});
    vecs.push_back('{80, 1'b1, 8'h00, 8'h00, 4'b0100, 1'b1, 4'b1111, 3, 4'h0, 0, 1});
    vecs.push_back('{81, 1'b0, 8'h00, 8'h00, 4'b0100, 1'b1, 4'b1110, 0, 4'h0, 0, 0});
    vecs.push_back('{85, 1'b0, 8'h00, 8'h00, 4'b0100, 1'b1, 4'b1101, 1, 4'h0, 0, 0});
    vecs.push_back('{89, 1'b0, 8'h00, 8'h00, 4'b0100, 1'b1, 4'b1011, 2, 4'h0, 1, 0});
    vecs.push_back('{93, 1'b0, 8'h00, 8'h00, 4'b0100, 1'b1, 4'b1111, 3, 4'h0, 0, 0});
    vecs.push_back('{94, 1'b0, 8'h00, 8'h00, 4'b0100, 1'b0, 4'b0111, 3, 4'h0, 0, 0});

    drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_reset_outputs("reset");
    release_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].nl, vecs[i].nr, vecs[i].dots, vecs[i].blz);
      step_to(vecs[i].k);
      chk($sformatf("v%0d anode", i), {4'h0, bus.anode_out},  {4'h0, vecs[i].anode});
      chk($sformatf("v%0d sel", i),   {6'h0, bus.digit_sel},  {6'h0, vecs[i].sel});
      chk($sformatf("v%0d nib", i),   {4'h0, bus.nibble_out}, {4'h0, vecs[i].nib});
      chk($sformatf("v%0d dot", i),   {7'h0, bus.dot_out},    {7'h0, vecs[i].dot});
      chk($sformatf("v%0d ack", i),   {7'h0, bus.load_ack},   {7'h0, vecs[i].ack});
    end
    chk("ack pulses in table", ack_cnt[7:0], 8'd4);

    // Tear-free: load 1234, then scramble inputs every cycle with no request.
    drive(1'b1, 8'h12, 8'h34, 4'h0, 1'b0);
    step_to(96);
    chk("tearfree load ack", {7'h0, bus.load_ack}, 8'h01);
    for (int k = 97; k <= 128; k++) begin
      drive(1'b0, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
      step();
      begin
        int d;
        d = ((cyc - 1) / 4) % 4;
        chk($sformatf("tearfree sel k%0d", cyc), {6'h0, bus.digit_sel}, 8'(d));
        chk($sformatf("tearfree nib k%0d", cyc), {4'h0, bus.nibble_out}, 8'(4 - d));
      end
    end
    chk("tearfree no ack", ack_cnt[7:0], 8'd5);

    // Reset asserted while digit 2 is active and a request is pending.
    step_to(137);
    drive(1'b1, 8'h9A, 8'hBC, 4'h0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    ack_cnt = 0;
    repeat (3) begin
      @(posedge i_clk);
      #1;
      if (bus.load_ack === 1'b1) ack_cnt++;
    end
    chk("midreset no ack", ack_cnt[7:0], 8'd0);
    release_reset();

    // Request held across three frames: one ack per boundary.
    step_to(2);
    chk("post reset anode", {4'h0, bus.anode_out},  8'h0E);
    chk("post reset nib",   {4'h0, bus.nibble_out}, 8'h00);
    step_to(15);
    chk("b2b ack k15", {7'h0, bus.load_ack}, 8'h00);
    step_to(16);
    chk("b2b ack k16", {7'h0, bus.load_ack}, 8'h01);
    step_to(17);
    chk("b2b ack k17", {7'h0, bus.load_ack}, 8'h00);
    chk("b2b nib k17", {4'h0, bus.nibble_out}, 8'h0C);
    step_to(31);
    chk("b2b count k31", ack_cnt[7:0], 8'd1);
    step_to(32);
    chk("b2b ack k32", {7'h0, bus.load_ack}, 8'h01);
    step_to(47);
    chk("b2b count k47", ack_cnt[7:0], 8'd2);
    step_to(48);
    chk("b2b ack k48", {7'h0, bus.load_ack}, 8'h01);
    drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
    step_to(64);
    chk("b2b ack k64", {7'h0, bus.load_ack}, 8'h00);
    chk("b2b count end", ack_cnt[7:0], 8'd3);
    step_to(65);
    chk("b2b shadow kept", {4'h0, bus.nibble_out}, 8'h0C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
